cordic_multi_timer: RTL

Parametrised multi-channel interval timer, the successor to the single-channel 16-bit-bus system timer on the Nios II CORDIC platform. It presents CHANNELS independent down-counters behind one Avalon-MM slave, with configurable counter and data width. Each channel has one-shot or continuous mode, snapshot capture and a per-channel timeout flag. It also drives a single OR-combined interrupt to the CPU.

---
 rtl/cordic_multi_timer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/cordic_multi_timer.sv
// cordic_multi_timer
// CHANNELS independent down-counting interval timers behind one Avalon-MM
// slave. Address is {channel, reg[1:0]}; regs are STATUS, CONTROL, PERIOD, SNAP.
// Each channel runs one-shot or continuous, supports snapshot capture and
// raises TO on timeout; irq is the OR over channels of (TO && ITO).
// Optional feature: define CORDIC_TIMER_PRESCALER_EN to give every channel an
// 8-bit prescaler in CONTROL[11:4] (counter steps once every PRE+1 clocks).
module cordic_multi_timer #(
  parameter int CHANNELS     = 2,
  parameter int COUNT_W      = 32,
  parameter int RESET_PERIOD = 99999
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [$clog2(CHANNELS)+1:0] address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [COUNT_W-1:0]          writedata,
  output logic [COUNT_W-1:0]          readdata,
  output logic                        irq
);

  localparam logic [1:0]         REG_STATUS  = 2'd0;
  localparam logic [1:0]         REG_CONTROL = 2'd1;
  localparam logic [1:0]         REG_PERIOD  = 2'd2;
  localparam logic [1:0]         REG_SNAP    = 2'd3;
  localparam logic [COUNT_W-1:0] RESET_VAL   = COUNT_W'(RESET_PERIOD);
  localparam logic [COUNT_W-1:0] CNT_ZERO    = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE     = {{(COUNT_W-1){1'b0}}, 1'b1};

  // Per-channel architectural state
  logic [COUNT_W-1:0]  period_r [CHANNELS];
  logic [COUNT_W-1:0]  count_r  [CHANNELS];
  logic [COUNT_W-1:0]  snap_r   [CHANNELS];
  logic [CHANNELS-1:0] to_r;
  logic [CHANNELS-1:0] run_r;
  logic [CHANNELS-1:0] ito_r;
  logic [CHANNELS-1:0] cont_r;
  logic [CHANNELS-1:0] reload_pend_r;
`ifdef CORDIC_TIMER_PRESCALER_EN
  logic [7:0]          pre_r     [CHANNELS];
  logic [7:0]          pre_cnt_r [CHANNELS];
`endif

  // Bus decode and per-channel strobes
  logic [31:0]         ch_sel_s;
  logic [1:0]          reg_sel_s;
  logic [31:0]         wd_s;
  logic [CHANNELS-1:0] sel_s;
  logic [CHANNELS-1:0] status_wr_s;
  logic [CHANNELS-1:0] control_wr_s;
  logic [CHANNELS-1:0] period_wr_s;
  logic [CHANNELS-1:0] snap_wr_s;
  logic [CHANNELS-1:0] start_s;
  logic [CHANNELS-1:0] stop_s;
  logic [CHANNELS-1:0] tick_s;
  logic [CHANNELS-1:0] timeout_s;
  logic [COUNT_W-1:0]  rd_s;

  // Split the address into channel/register fields and widen the write data
  always_comb begin
    ch_sel_s  = 32'(address >> 2'd2);
    reg_sel_s = address[1:0];
    wd_s      = 32'(writedata);
  end

  // Per-channel write strobes, count tick and timeout event
  always_comb begin
    sel_s        = {CHANNELS{1'b0}};
    status_wr_s  = {CHANNELS{1'b0}};
    control_wr_s = {CHANNELS{1'b0}};
    period_wr_s  = {CHANNELS{1'b0}};
    snap_wr_s    = {CHANNELS{1'b0}};
    start_s      = {CHANNELS{1'b0}};
    stop_s       = {CHANNELS{1'b0}};
    tick_s       = {CHANNELS{1'b0}};
    timeout_s    = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      sel_s[c]        = chipselect && !write_n && (ch_sel_s == 32'(c));
      status_wr_s[c]  = sel_s[c] && (reg_sel_s == REG_STATUS);
      control_wr_s[c] = sel_s[c] && (reg_sel_s == REG_CONTROL);
      period_wr_s[c]  = sel_s[c] && (reg_sel_s == REG_PERIOD);
      snap_wr_s[c]    = sel_s[c] && (reg_sel_s == REG_SNAP);
      // START and STOP together: START wins
      start_s[c]      = control_wr_s[c] && wd_s[2];
      stop_s[c]       = control_wr_s[c] && wd_s[3] && !wd_s[2];
`ifdef CORDIC_TIMER_PRESCALER_EN
      tick_s[c]       = (pre_cnt_r[c] == pre_r[c]);
`else
      tick_s[c]       = 1'b1;
`endif
      timeout_s[c]    = run_r[c] && (count_r[c] == CNT_ZERO) && tick_s[c];
    end
  end

  // Channel state: counter, reload, run control, timeout flag, config, snapshot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        period_r[c]      <= RESET_VAL;
        count_r[c]       <= RESET_VAL;
        snap_r[c]        <= CNT_ZERO;
        to_r[c]          <= 1'b0;
        run_r[c]         <= 1'b0;
        ito_r[c]         <= 1'b0;
        cont_r[c]        <= 1'b0;
        reload_pend_r[c] <= 1'b0;
`ifdef CORDIC_TIMER_PRESCALER_EN
        pre_r[c]         <= 8'd0;
        pre_cnt_r[c]     <= 8'd0;
`endif
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        // A PERIOD write reloads the counter one edge later
        reload_pend_r[c] <= period_wr_s[c];

        if (reload_pend_r[c]) begin
          count_r[c] <= period_r[c];
        end else if (run_r[c] && tick_s[c]) begin
          if (count_r[c] == CNT_ZERO) begin
            count_r[c] <= period_r[c];
          end else begin
            count_r[c] <= count_r[c] - CNT_ONE;
          end
        end else begin
          count_r[c] <= count_r[c];
        end

        // PERIOD write stops the channel, even against START
        if (period_wr_s[c]) begin
          run_r[c] <= 1'b0;
        end else if (start_s[c]) begin
          run_r[c] <= 1'b1;
        end else if (stop_s[c]) begin
          run_r[c] <= 1'b0;
        end else if (timeout_s[c] && !cont_r[c]) begin
          run_r[c] <= 1'b0;
        end else begin
          run_r[c] <= run_r[c];
        end

        // A timeout beats a simultaneous STATUS clear
        if (timeout_s[c]) begin
          to_r[c] <= 1'b1;
        end else if (status_wr_s[c]) begin
          to_r[c] <= 1'b0;
        end else begin
          to_r[c] <= to_r[c];
        end

        if (control_wr_s[c]) begin
          ito_r[c]  <= wd_s[0];
          cont_r[c] <= wd_s[1];
`ifdef CORDIC_TIMER_PRESCALER_EN
          pre_r[c]  <= wd_s[11:4];
`endif
        end else begin
          ito_r[c]  <= ito_r[c];
          cont_r[c] <= cont_r[c];
        end

        if (period_wr_s[c]) begin
          period_r[c] <= writedata;
        end else begin
          period_r[c] <= period_r[c];
        end

        if (snap_wr_s[c]) begin
          snap_r[c] <= count_r[c];
        end else begin
          snap_r[c] <= snap_r[c];
        end

`ifdef CORDIC_TIMER_PRESCALER_EN
        if (start_s[c] || reload_pend_r[c]) begin
          pre_cnt_r[c] <= 8'd0;
        end else if (run_r[c]) begin
          pre_cnt_r[c] <= tick_s[c] ? 8'd0 : (pre_cnt_r[c] + 8'd1);
        end else begin
          pre_cnt_r[c] <= pre_cnt_r[c];
        end
`endif
      end
    end
  end

  // Read mux: OR of the addressed channel's register, zero for missing channels
  always_comb begin
    rd_s = CNT_ZERO;
    for (int c = 0; c < CHANNELS; c++) begin
      logic [COUNT_W-1:0] chan_rd_s;
      case (reg_sel_s)
        REG_STATUS:  chan_rd_s = COUNT_W'({run_r[c], to_r[c]});
`ifdef CORDIC_TIMER_PRESCALER_EN
        REG_CONTROL: chan_rd_s = COUNT_W'({pre_r[c], 2'b00, cont_r[c], ito_r[c]});
`else
        REG_CONTROL: chan_rd_s = COUNT_W'({cont_r[c], ito_r[c]});
`endif
        REG_PERIOD:  chan_rd_s = period_r[c];
        REG_SNAP:    chan_rd_s = snap_r[c];
        default:     chan_rd_s = CNT_ZERO;
      endcase
      rd_s = rd_s | ((ch_sel_s == 32'(c)) ? chan_rd_s : CNT_ZERO);
    end
  end

  // Registered read data, refreshed every cycle from the address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= CNT_ZERO;
    end else begin
      readdata <= rd_s;
    end
  end

  // Interrupt follows the TO/ITO registers directly
  always_comb begin
    irq = |(to_r & ito_r);
  end

endmodule
